// File: rtl/tc_fetch_if.sv
// tc_fetch_if: program-memory, decoder and control signals of the fetch stage
interface tc_fetch_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_b0, mem_b1, mem_b2, mem_b3;
    logic [31:0]       instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              instr_ready;
    logic              redirect_en;
    logic [ADDR_W-1:0] redirect_pc;
    logic              halt_req;
    logic              resume;
    logic              halted;

    modport master (
        output mem_addr, instr, instr_pc, instr_valid, halted,
        input  mem_b0, mem_b1, mem_b2, mem_b3, instr_ready, redirect_en, redirect_pc, halt_req, resume
    );

    modport slave (
        input  mem_addr, instr, instr_pc, instr_valid, halted,
        output mem_b0, mem_b1, mem_b2, mem_b3, instr_ready, redirect_en, redirect_pc, halt_req, resume
    );
endinterface

// File: rtl/tc_fetch_unit.sv
// tc_fetch_unit: fetch PC, program-memory addressing and a small instruction queue
module tc_fetch_unit #(
    parameter int ADDR_W   = 8,
    parameter int STEP     = 4,
    parameter int RESET_PC = 0,
    parameter int DEPTH    = 2
) (
    input logic       clk,
    input logic       rst,
    tc_fetch_if.master f
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic {RUN, HALTED} state_t;

    state_t            state;
    logic [ADDR_W-1:0] fpc;
    logic [31:0]       q_word [DEPTH];
    logic [ADDR_W-1:0] q_pc [DEPTH];
    logic [PW-1:0]     rd, wr;
    logic [CW-1:0]     count;
    logic              push, pop;

    assign pop           = f.instr_valid & f.instr_ready;
    assign push          = state == RUN && !f.redirect_en && !f.halt_req && (count < FULL || pop);
    assign f.mem_addr    = fpc;
    assign f.instr_valid = count != '0;
    assign f.instr       = f.instr_valid ? q_word[rd] : '0;
    assign f.instr_pc    = f.instr_valid ? q_pc[rd] : '0;

    // queue storage needs no reset: count gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            q_word[wr] <= {f.mem_b3, f.mem_b2, f.mem_b1, f.mem_b0};
            q_pc[wr]   <= fpc;
        end
    end

    // fetch PC, queue pointers and RUN/HALTED control; redirect flushes and freezes state
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            f.halted <= 1'b0;
            fpc      <= ADDR_W'(RESET_PC);
            rd       <= '0;
            wr       <= '0;
            count    <= '0;
        end else if (f.redirect_en) begin
            fpc   <= f.redirect_pc;
            rd    <= '0;
            wr    <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wr  <= wr + PW'(1);
                fpc <= fpc + ADDR_W'(STEP);
            end
            if (pop) rd <= rd + PW'(1);
            count <= push && !pop ? count + CW'(1) : !push && pop ? count - CW'(1) : count;
            if (state == RUN && f.halt_req) begin
                state    <= HALTED;
                f.halted <= 1'b1;
            end else if (state == HALTED && f.resume) begin
                state    <= RUN;
                f.halted <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_tc_fetch_unit.sv
// tb_tc_fetch_unit: directed and random stimulus against a queue-based reference model
module tb_tc_fetch_unit;
    localparam int DEPTH = 2;

    typedef struct packed {
        logic [31:0] w;
        logic [7:0]  pc;
    } entry_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    entry_t     q[$];
    logic [7:0] m_fpc;
    logic       m_halt;

    tc_fetch_if #(.ADDR_W(8)) f ();

    tc_fetch_unit #(.ADDR_W(8), .STEP(4), .RESET_PC(0), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .f(f)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mb(input logic [7:0] a);
        return (a * 8'd7) ^ 8'h3C;
    endfunction

    function automatic logic [31:0] word(input logic [7:0] a);
        return {mb(a + 8'd3), mb(a + 8'd2), mb(a + 8'd1), mb(a)};
    endfunction

    // program memory: bytes derived from their address
    always_comb begin
        f.mem_b0 = mb(f.mem_addr);
        f.mem_b1 = mb(f.mem_addr + 8'd1);
        f.mem_b2 = mb(f.mem_addr + 8'd2);
        f.mem_b3 = mb(f.mem_addr + 8'd3);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic rdy, input logic red, input logic [7:0] rpc,
                        input logic h, input logic res);
        logic pop, push;
        rst           = r;
        f.instr_ready = rdy;
        f.redirect_en = red;
        f.redirect_pc = rpc;
        f.halt_req    = h;
        f.resume      = res;
        chk("instr_valid", f.instr_valid, q.size() != 0);
        chk("instr", f.instr, q.size() != 0 ? q[0].w : 32'h0);
        chk("instr_pc", f.instr_pc, q.size() != 0 ? q[0].pc : 8'h0);
        chk("halted", f.halted, m_halt);
        chk("mem_addr", f.mem_addr, m_fpc);
        if (r) begin
            q.delete();
            m_fpc  = 8'h00;
            m_halt = 1'b0;
        end else if (red) begin
            q.delete();
            m_fpc = rpc;
        end else begin
            pop  = q.size() != 0 && rdy;
            push = !m_halt && !h && (q.size() < DEPTH || pop);
            if (pop) void'(q.pop_front());
            if (push) begin
                q.push_back('{w: word(m_fpc), pc: m_fpc});
                m_fpc = m_fpc + 8'd4;
            end
            if (!m_halt && h) m_halt = 1'b1;
            else if (m_halt && res) m_halt = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(0, rdy, 0, 8'h00, 0, 0);
    endtask

    initial begin
        f.instr_ready = 1'b0;
        f.redirect_en = 1'b0;
        f.redirect_pc = 8'h00;
        f.halt_req    = 1'b0;
        f.resume      = 1'b0;
        m_fpc         = 8'h00;
        m_halt        = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        // streaming with ready=1: pcs 0,4,8... one per cycle
        run(8, 1);
        // backpressure: exactly DEPTH pushes, head held at pc 0
        step(1, 0, 0, 8'h00, 0, 0);
        run(10, 0);
        chk("bp_mem_addr", f.mem_addr, 32'h08);
        chk("bp_instr_pc", f.instr_pc, 32'h00);
        run(6, 1);
        // redirect while full with ready=1
        step(1, 0, 0, 8'h00, 0, 0);
        run(3, 0);
        step(0, 1, 1, 8'h40, 0, 0);
        chk("redir_flush", f.instr_valid, 32'h0);
        step(0, 1, 0, 8'h00, 0, 0);
        chk("redir_pc40", f.instr_pc, 32'h40);
        run(4, 1);
        // redirect near the top of the address space wraps
        step(0, 1, 1, 8'hF8, 0, 0);
        run(6, 1);
        // halt at pc 0x10, drain, resume, then halt+resume together
        step(1, 1, 0, 8'h00, 0, 0);
        for (int i = 0; i < 20 && m_fpc != 8'h10; i++) step(0, 1, 0, 8'h00, 0, 0);
        chk("halt_at_pc10", f.mem_addr, 32'h10);
        step(0, 1, 0, 8'h00, 1, 0);
        chk("halted_set", f.halted, 32'h1);
        run(4, 1);
        chk("halt_no_fetch", f.mem_addr, 32'h10);
        step(0, 1, 0, 8'h00, 0, 1);
        run(4, 1);
        step(0, 1, 0, 8'h00, 1, 1);
        chk("halt_wins", f.halted, 32'h1);
        step(0, 1, 1, 8'h80, 0, 0);
        step(0, 0, 0, 8'h00, 0, 1);
        run(4, 0);
        // reset with a full queue
        step(1, 0, 0, 8'h00, 0, 0);
        chk("rst_valid", f.instr_valid, 32'h0);
        chk("rst_instr", f.instr, 32'h0);
        chk("rst_mem_addr", f.mem_addr, 32'h0);
        // random traffic
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                 8'($urandom_range(0, 255)), $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
